// File: rtl/input_mems_pingpong_pkg.sv
// Shared types and width helpers for the ping-pong matrix input memories.
package input_mems_pkg;
    typedef enum logic [1:0] {L_IDLE, L_A, L_B} load_state_t;
    typedef enum logic {C_IDLE, C_BUSY} cmp_state_t;

    function automatic int k_bits(input int maxk);
        return $clog2(maxk + 1);
    endfunction

    function automatic int addr_bits(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction
endpackage

// File: rtl/input_mems_pingpong_if.sv
// AXI-Stream slave bundle carrying matrix elements plus new_A/K sideband in TUSER.
interface input_mems_pingpong_if #(
    parameter int INW = 12,
    parameter int UW  = 5
);
    logic [INW-1:0] AXIS_TDATA;
    logic           AXIS_TVALID;
    logic [UW-1:0]  AXIS_TUSER;
    logic           AXIS_TREADY;

    modport master (output AXIS_TDATA, AXIS_TVALID, AXIS_TUSER, input AXIS_TREADY);
    modport slave  (input AXIS_TDATA, AXIS_TVALID, AXIS_TUSER, output AXIS_TREADY);
endinterface

// File: rtl/input_mems_pingpong_mem.sv
// Simple dual-port memory: one write port, one registered read port (1-cycle latency).
module input_mems_pingpong_mem
    import input_mems_pkg::*;
#(
    parameter int W     = 12,
    parameter int DEPTH = 56,
    localparam int AW   = addr_bits(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);
    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (reset) rdata <= '0;
        else       rdata <= mem[raddr];
    end
endmodule

// File: rtl/input_mems_pingpong.sv
// A (single buffer) and B (two banks) input memories fed by AXI-Stream for the matmul unit.
// Optional K/new_A sanity checking with sticky k_err is enabled by INPUT_MEMS_KCHK_EN.
module input_mems_pingpong
    import input_mems_pkg::*;
#(
    parameter int INW  = 12,
    parameter int M    = 7,
    parameter int N    = 9,
    parameter int MAXK = 8,
    localparam int K_BITS      = k_bits(MAXK),
    localparam int A_ADDR_BITS = addr_bits(M * MAXK),
    localparam int B_ADDR_BITS = addr_bits(MAXK * N)
) (
    input  logic                          clk,
    input  logic                          reset,
    input_mems_pingpong_if.slave          axis,
    output logic                          matrices_loaded,
    input  logic                          compute_finished,
    output logic        [K_BITS-1:0]      K,
    input  logic        [A_ADDR_BITS-1:0] A_read_addr,
    output logic signed [INW-1:0]         A_data,
    input  logic        [B_ADDR_BITS-1:0] B_read_addr,
    output logic signed [INW-1:0]         B_data,
`ifdef INPUT_MEMS_KCHK_EN
    output logic                          k_err,
`endif
    output logic        [1:0]             bank_full
);
    load_state_t lstate, lstate_nx;
    cmp_state_t  cstate, cstate_nx;

    logic [K_BITS-1:0]      a_k, k_in, k_sel;
    logic [1:0][K_BITS-1:0] bank_k;
    logic [A_ADDR_BITS-1:0] a_cnt, a_idx;
    logic [B_ADDR_BITS-1:0] b_cnt, b_idx;
    logic [A_ADDR_BITS:0]   mk;
    logic [B_ADDR_BITS:0]   kn;
    logic load_bank, cmp_bank, rd_bank;
    logic new_a, tready, xfer, bad_beat;
    logic a_we, b_we, a_last, b_last, cmp_start, cmp_done;
    logic [1:0] set_mask, clr_mask;
    logic [1:0][INW-1:0] b_rd;

    assign new_a = axis.AXIS_TUSER[0];
    assign k_in  = axis.AXIS_TUSER[K_BITS:1];

`ifdef INPUT_MEMS_KCHK_EN
    logic a_valid;
    assign bad_beat = (lstate == L_IDLE) &&
                      (new_a ? (k_in == '0 || int'(k_in) > MAXK) : !a_valid);
`else
    assign bad_beat = 1'b0;
`endif

    // A new A may only start once nothing downstream still depends on the old one.
    always_comb begin
        tready = 1'b0;
        unique case (lstate)
            L_IDLE:  tready = new_a ? (cstate == C_IDLE && bank_full == 2'b00)
                                    : !bank_full[load_bank];
            L_A:     tready = 1'b1;
            default: tready = !bank_full[load_bank];
        endcase
    end
    assign axis.AXIS_TREADY = tready;
    assign xfer = axis.AXIS_TVALID && tready;

    // K of the first beat is not latched yet, so size the A phase from TUSER directly.
    assign k_sel  = (lstate == L_IDLE) ? k_in : a_k;
    assign mk     = (A_ADDR_BITS+1)'(M) * (A_ADDR_BITS+1)'(k_sel);
    assign kn     = (B_ADDR_BITS+1)'(N) * (B_ADDR_BITS+1)'(a_k);
    assign a_idx  = (lstate == L_IDLE) ? '0 : a_cnt;
    assign b_idx  = (lstate == L_IDLE) ? '0 : b_cnt;
    assign a_we   = xfer && !bad_beat && (lstate == L_A || (lstate == L_IDLE && new_a));
    assign b_we   = xfer && !bad_beat && (lstate == L_B || (lstate == L_IDLE && !new_a));
    assign a_last = {1'b0, a_idx} == mk - 1'b1;
    assign b_last = {1'b0, b_idx} == kn - 1'b1;

    assign cmp_start = (cstate == C_IDLE) && bank_full[cmp_bank];
    assign cmp_done  = (cstate == C_BUSY) && compute_finished;
    assign set_mask  = (b_we && b_last) ? (2'b01 << load_bank) : 2'b00;
    assign clr_mask  = cmp_done ? (2'b01 << cmp_bank) : 2'b00;

    always_comb begin
        lstate_nx = lstate;
        if (a_we) lstate_nx = a_last ? L_B : L_A;
        if (b_we) lstate_nx = b_last ? L_IDLE : L_B;
    end

    always_comb begin
        cstate_nx = cstate;
        unique case (cstate)
            C_IDLE:  if (bank_full[cmp_bank]) cstate_nx = C_BUSY;
            default: if (compute_finished)    cstate_nx = C_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lstate          <= L_IDLE;
            cstate          <= C_IDLE;
            a_k             <= '0;
            a_cnt           <= '0;
            b_cnt           <= '0;
            bank_k          <= '0;
            load_bank       <= 1'b0;
            cmp_bank        <= 1'b0;
            rd_bank         <= 1'b0;
            bank_full       <= 2'b00;
            matrices_loaded <= 1'b0;
            K               <= '0;
        end else begin
            lstate    <= lstate_nx;
            cstate    <= cstate_nx;
            bank_full <= (bank_full | set_mask) & ~clr_mask;
            rd_bank   <= cmp_bank;
            if (a_we) begin
                if (lstate == L_IDLE) a_k <= k_in;
                if (a_last) b_cnt <= '0;
                else        a_cnt <= a_idx + 1'b1;
            end
            if (b_we) begin
                if (b_last) begin
                    bank_k[load_bank] <= a_k;
                    load_bank         <= ~load_bank;
                end else begin
                    b_cnt <= b_idx + 1'b1;
                end
            end
            if (cmp_start) begin
                matrices_loaded <= 1'b1;
                K               <= bank_k[cmp_bank];
            end
            if (cmp_done) begin
                matrices_loaded <= 1'b0;
                cmp_bank        <= ~cmp_bank;
            end
        end
    end

`ifdef INPUT_MEMS_KCHK_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            a_valid <= 1'b0;
            k_err   <= 1'b0;
        end else begin
            if (a_we && a_last)   a_valid <= 1'b1;
            if (xfer && bad_beat) k_err   <= 1'b1;
        end
    end
`endif

    input_mems_pingpong_mem #(.W(INW), .DEPTH(M * MAXK)) u_a_mem (
        .clk(clk), .reset(reset), .we(a_we), .waddr(a_idx),
        .wdata(axis.AXIS_TDATA), .raddr(A_read_addr), .rdata(A_data)
    );

    for (genvar b = 0; b < 2; b++) begin : g_bmem
        input_mems_pingpong_mem #(.W(INW), .DEPTH(MAXK * N)) u_b_mem (
            .clk(clk), .reset(reset), .we(b_we && (load_bank == 1'(b))), .waddr(b_idx),
            .wdata(axis.AXIS_TDATA), .raddr(B_read_addr), .rdata(b_rd[b])
        );
    end

    // Select with the bank captured alongside the read address, not the live one.
    assign B_data = b_rd[rd_bank];
endmodule

// File: tb/tb_input_mems_pingpong.sv
// Self-checking bench for input_mems_pingpong; build with INPUT_MEMS_KCHK_EN to cover k_err.
module tb_input_mems_pingpong;
    localparam int INW  = 12;
    localparam int M    = 7;
    localparam int N    = 9;
    localparam int MAXK = 8;
    localparam int KB   = $clog2(MAXK + 1);
    localparam int AAB  = $clog2(M * MAXK);
    localparam int BAB  = $clog2(MAXK * N);

    logic clk = 1'b0;
    logic reset;
    logic matrices_loaded, compute_finished, k_err;
    logic [KB-1:0]  K;
    logic [AAB-1:0] A_read_addr;
    logic [BAB-1:0] B_read_addr;
    logic [INW-1:0] A_data, B_data;
    logic [1:0]     bank_full;

    always #5 clk = ~clk;

    input_mems_pingpong_if #(.INW(INW), .UW(KB + 1)) axis ();

    input_mems_pingpong #(.INW(INW), .M(M), .N(N), .MAXK(MAXK)) dut (
        .clk(clk), .reset(reset), .axis(axis),
        .matrices_loaded(matrices_loaded), .compute_finished(compute_finished), .K(K),
        .A_read_addr(A_read_addr), .A_data(A_data),
        .B_read_addr(B_read_addr), .B_data(B_data),
`ifdef INPUT_MEMS_KCHK_EN
        .k_err(k_err),
`endif
        .bank_full(bank_full)
    );

`ifndef INPUT_MEMS_KCHK_EN
    assign k_err = 1'b0;
`endif

    int pass_cnt = 0;
    int total    = 0;

    // Reference model: current A matrix and a FIFO (depth 2) of loaded-but-unconsumed B banks.
    logic [INW-1:0] a_mat [M*MAXK];
    int             a_k = 0;
    logic [INW-1:0] bd [2][MAXK*N];
    int             bk [2];
    int             head = 0;
    int             cnt  = 0;

    typedef struct {
        int a_addr;
        int b_addr;
        int exp_a;
        int exp_b;
    } rd_vec_t;
    rd_vec_t tbl [4];

    task automatic check(input string name, input longint got, input longint exp);
        total++;
        if (got == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", name, got, exp);
    endtask

    task automatic send_beat(input logic [INW-1:0] d, input logic [KB:0] u, input bit fin);
        @(negedge clk);
        axis.AXIS_TDATA  = d;
        axis.AXIS_TUSER  = u;
        axis.AXIS_TVALID = 1'b1;
        compute_finished = fin;
        for (int t = 0; t <= 500; t++) begin
            #1;
            if (axis.AXIS_TREADY) break;
            if (t == 500) begin
                check("tready_timeout", 0, 1);
                axis.AXIS_TVALID = 1'b0;
                compute_finished = 1'b0;
                return;
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        axis.AXIS_TVALID = 1'b0;
        compute_finished = 1'b0;
    endtask

    // base < 0 selects random data; last_fin pulses compute_finished with the final beat.
    task automatic send_packet(input bit new_a, input int kuser, input int base, input bit last_fin);
        int k, n_a, n_b, slot;
        logic [INW-1:0] v;
        logic [KB:0] u;
        k    = new_a ? kuser : a_k;
        n_a  = new_a ? M * k : 0;
        n_b  = k * N;
        slot = (head + cnt) % 2;
        u    = {KB'(kuser), new_a};
        for (int i = 0; i < n_a + n_b; i++) begin
            v = (base < 0) ? INW'($urandom) : INW'(base + i);
            if (i < n_a) a_mat[i] = v;
            else         bd[slot][i - n_a] = v;
            send_beat(v, u, last_fin && (i == n_a + n_b - 1));
        end
        if (new_a) a_k = k;
        bk[slot] = k;
        if (last_fin) begin
            head = (head + 1) % 2;
            cnt--;
        end
        cnt++;
    endtask

    task automatic probe_ready(input string name, input logic [KB:0] u, input int exp);
        @(negedge clk);
        axis.AXIS_TUSER  = u;
        axis.AXIS_TVALID = 1'b1;
        #1;
        check(name, axis.AXIS_TREADY, exp);
        axis.AXIS_TVALID = 1'b0;
    endtask

    task automatic verify_front(input string tag);
        for (int t = 0; t < 50 && !matrices_loaded; t++) @(negedge clk);
        check({tag, "_loaded"}, matrices_loaded, 1);
        check({tag, "_K"}, K, bk[head]);
        for (int r = 0; r < 4; r++) begin
            int aa, ba;
            aa = $urandom_range(M * a_k - 1);
            ba = $urandom_range(bk[head] * N - 1);
            @(negedge clk);
            A_read_addr = AAB'(aa);
            B_read_addr = BAB'(ba);
            @(negedge clk);
            check({tag, "_A_data"}, A_data, a_mat[aa]);
            check({tag, "_B_data"}, B_data, bd[head][ba]);
        end
    endtask

    task automatic finish_front(input string tag);
        @(negedge clk);
        compute_finished = 1'b1;
        @(negedge clk);
        compute_finished = 1'b0;
        check({tag, "_loaded_drop"}, matrices_loaded, 0);
        head = (head + 1) % 2;
        cnt--;
    endtask

    initial begin
        logic [1:0] prev;
        bit na;

        tbl[0] = '{5, 0, 6, 22};
        tbl[1] = '{0, 26, 1, 48};
        tbl[2] = '{20, 13, 21, 35};
        tbl[3] = '{12, 5, 13, 27};

        axis.AXIS_TDATA  = '0;
        axis.AXIS_TUSER  = '0;
        axis.AXIS_TVALID = 1'b0;
        compute_finished = 1'b0;
        A_read_addr      = '0;
        B_read_addr      = '0;
        reset            = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_loaded", matrices_loaded, 0);
        check("rst_K", K, 0);
        check("rst_A_data", A_data, 0);
        check("rst_B_data", B_data, 0);
        check("rst_bank_full", bank_full, 0);
        check("rst_k_err", k_err, 0);
        reset = 1'b0;

        // First load: new_A, K=3, values 1..48.
        send_packet(1'b1, 3, 1, 1'b0);
        verify_front("pkt1");
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            A_read_addr = AAB'(tbl[i].a_addr);
            B_read_addr = BAB'(tbl[i].b_addr);
            @(negedge clk);
            check("tbl_A_data", A_data, tbl[i].exp_a);
            check("tbl_B_data", B_data, tbl[i].exp_b);
        end

        // Second bank loads during compute; TUSER K=5 is ignored.
        send_packet(1'b0, 5, 101, 1'b0);
        check("pkt2_bank_full", bank_full, 2'b11);

        // Both banks full: further B stalls until one is released.
        probe_ready("pkt3_blocked", {KB'(3), 1'b0}, 0);
        finish_front("pkt1");
        @(negedge clk);
        check("pkt2_reloaded", matrices_loaded, 1);
        check("pkt2_K", K, 3);
        verify_front("pkt2");
        send_packet(1'b0, 0, 201, 1'b0);
        check("pkt3_bank_full", bank_full, 2'b11);

        // new_A waits until both banks drain and compute is idle.
        probe_ready("newA_blocked_2full", {KB'(2), 1'b1}, 0);
        finish_front("pkt2");
        verify_front("pkt3");
        probe_ready("newA_blocked_1full", {KB'(2), 1'b1}, 0);
        finish_front("pkt3");
        probe_ready("newA_free", {KB'(2), 1'b1}, 1);
        send_packet(1'b1, 2, -1, 1'b0);
        verify_front("pkt4");

        // Last B beat coincides with compute_finished on the other bank.
        prev = bank_full;
        send_packet(1'b0, 7, -1, 1'b1);
        check("simul_bank_full", bank_full, (~prev) & 2'b11);
        check("simul_loaded_drop", matrices_loaded, 0);
        verify_front("simul");

        for (int it = 0; it < 8; it++) begin
            na = ($urandom_range(2) == 0);
            if (na) begin
                while (cnt > 0) begin
                    verify_front("rnd");
                    finish_front("rnd");
                end
            end else if (cnt == 2) begin
                verify_front("rnd");
                finish_front("rnd");
            end
            send_packet(na, $urandom_range(MAXK, 1), -1, 1'b0);
        end
        while (cnt > 0) begin
            verify_front("drain");
            finish_front("drain");
        end
        repeat (2) @(negedge clk);
        check("drain_bank_full", bank_full, 0);

`ifdef INPUT_MEMS_KCHK_EN
        send_beat(INW'(12'h5a5), {KB'(0), 1'b1}, 1'b0);
        repeat (3) @(negedge clk);
        check("kchk_k_err", k_err, 1);
        check("kchk_loaded", matrices_loaded, 0);
        check("kchk_bank_full", bank_full, 0);
        send_packet(1'b1, 4, -1, 1'b0);
        verify_front("kchk_next");
        finish_front("kchk_next");
        check("kchk_sticky", k_err, 1);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
